wb_stage_pipe: RTL
==================

Name: wb_stage_pipe

Overview:
- Parametrised MEM/WB pipeline register fused with the writeback stage.
- Captures MEM-stage results under stall/flush control.
- Performs load byte/half/word extraction with sign or zero extension.
- Selects among four result sources and drives the register-file write port.
- Maintains a retired-instruction counter (instret) for the CSR unit.
- Sits between mem_stage and the register file / forwarding unit.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
CNT_W, 64, instret counter width.
ZERO_GUARD, 1, when 1 suppresses wb_we for rd=0.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
stall  input  1  hold WB register contents
flush  input  1  insert bubble instead of capturing MEM-stage instruction
valid_mem  input  1  MEM-stage instruction is valid
mem_read_data_mem  input  XLEN  raw aligned-word/dword load data from data memory
alu_result_mem  input  XLEN  ALU result; also the load address
pc_plus4_mem  input  XLEN  PC+4 for JAL/JALR
csr_rdata_mem  input  XLEN  CSR read data
rd_mem  input  5  destination register
Reg_write_mem  input  1  register write enable
Result_src_mem  input  2  00 ALU, 01 load, 10 PC+4, 11 CSR
funct3_mem  input  3  load size/sign encoding
wb_data  output  XLEN  register-file write data
wb_rd  output  5  register-file write address
wb_we  output  1  register-file write enable
wb_valid  output  1  WB holds a valid instruction
instret  output  CNT_W  retired-instruction count

Behaviour:
- Reset:
  - On rst=1, asynchronously clear all WB registers and instret.
  - wb_data=0, wb_rd=0, wb_we=0, wb_valid=0, instret=0.
  - Reset asserted mid-operation discards the held instruction without counting it.
- Pipeline register, evaluated at each rising edge:
  - stall=1: hold all fields. stall has priority over flush.
  - stall=0, flush=1: valid_q=0, regwrite_q=0; other fields don't-care.
  - stall=0, flush=0: capture every *_mem input; valid_q=valid_mem.
- Latency: one cycle from MEM inputs to WB outputs. All outputs are combinational from the WB registers only; there is no input-to-output combinational path.
- Load extraction (Result_src_q=01):
  - Byte offset off = addr_q[1:0] for XLEN=32, addr_q[2:0] for XLEN=64.
  - Byte lane = data_q >> (8*off).
  - funct3 000 LB: sign-extend bits [7:0].
  - funct3 100 LBU: zero-extend bits [7:0].
  - funct3 001 LH: sign-extend [15:0].
  - funct3 101 LHU: zero-extend [15:0].
  - funct3 010 LW: XLEN=64 sign-extends [31:0]; XLEN=32 passes [31:0].
  - funct3 110 LWU: zero-extend [31:0] (XLEN=64 only).
  - funct3 011 LD: full 64 bits (XLEN=64 only).
  - Any other funct3: unshifted raw data_q.
  - Misaligned offsets are not trapped here; extraction uses the shifted lanes, with upper lanes zero-filled by the shift.
- Result mux: 00 alu_q, 01 extracted load, 10 pc4_q, 11 csr_q.
- wb_data is driven regardless of wb_we.
- wb_rd = rd_q.
- Write enable:
  - wb_we = valid_q & regwrite_q & ~(ZERO_GUARD & rd_q==0).
  - During stall, wb_we stays asserted for the held instruction. The repeated write is idempotent and required.
- wb_valid = valid_q.
- instret:
  - Increments by 1 at a rising edge where valid_q=1 and stall=0, i.e. the instruction leaves WB.
  - Counts each instruction exactly once, including bubbles' successors after flush; bubbles are not counted.
  - Wraps modulo 2^CNT_W with no saturation.

Test Plan:
1. Reset mid-stream: assert rst asynchronously between edges -> all outputs 0 immediately; instret=0; first valid ADD after release (rd=5, alu=0x12345678) -> next cycle wb_data=0x12345678, wb_rd=5, wb_we=1.
2. Load extraction, XLEN=32, mem data 0x80FF7F01:
   - LB off=1 -> 0x0000007F
   - LB off=2 -> 0xFFFFFFFF
   - LBU off=3 -> 0x00000080
   - LH off=2 -> 0xFFFF80FF
   - LHU off=0 -> 0x00007F01
   - LW -> 0x80FF7F01
3. Source mux: Result_src=10 with pc_plus4=0x1004 -> wb_data=0x1004. Result_src=11 with csr=0xABCD -> 0xABCD. rd=0 with Reg_write=1 -> wb_we=0 (ZERO_GUARD=1).
4. Stall/flush:
   - Valid instruction in WB; stall=1 for 3 cycles -> outputs held, wb_we=1 throughout, instret unchanged; after release instret +1.
   - stall=1 with flush=1 -> held, not bubbled.
   - flush=1 with stall=0 -> next cycle wb_valid=0, wb_we=0, no count.
5. Counter wrap, CNT_W=4: retire 17 valid instructions back-to-back -> instret reads 1. Interleave valid_mem=0 bubbles -> no increments for bubbles.
6. XLEN=64: mem data 0xFEDCBA9876543210:
   - LW off=4 -> 0xFFFFFFFFFEDCBA98
   - LWU off=4 -> 0x00000000FEDCBA98
   - LD -> full value

Source files
------------

// File: rtl/wb_stage_pipe_if.sv
// MEM -> WB bundle: MEM-stage results going in, register-file write port coming out.
interface wb_stage_pipe_if #(
   parameter int XLEN = 32
);
   logic            valid_mem;
   logic [XLEN-1:0] mem_read_data_mem;
   logic [XLEN-1:0] alu_result_mem;
   logic [XLEN-1:0] pc_plus4_mem;
   logic [XLEN-1:0] csr_rdata_mem;
   logic [4:0]      rd_mem;
   logic            Reg_write_mem;
   logic [1:0]      Result_src_mem;
   logic [2:0]      funct3_mem;

   logic [XLEN-1:0] wb_data;
   logic [4:0]      wb_rd;
   logic            wb_we;
   logic            wb_valid;

   // MEM stage side: produces results, observes the write port
   modport master (
      output valid_mem, mem_read_data_mem, alu_result_mem, pc_plus4_mem,
             csr_rdata_mem, rd_mem, Reg_write_mem, Result_src_mem, funct3_mem,
      input  wb_data, wb_rd, wb_we, wb_valid
   );

   // WB stage side: consumes results, drives the write port
   modport slave (
      input  valid_mem, mem_read_data_mem, alu_result_mem, pc_plus4_mem,
             csr_rdata_mem, rd_mem, Reg_write_mem, Result_src_mem, funct3_mem,
      output wb_data, wb_rd, wb_we, wb_valid
   );
endinterface

// File: rtl/wb_stage_pipe.sv
// MEM/WB pipeline register fused with writeback: load extraction, result
// selection, register-file write port and retired-instruction counter.
module wb_stage_pipe #(
   parameter int XLEN       = 32,
   parameter int CNT_W      = 64,
   parameter bit ZERO_GUARD = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             flush,
   wb_stage_pipe_if.slave   bus,
   output logic [CNT_W-1:0] instret
);

   localparam int OFF_W = (XLEN == 64) ? 3 : 2;

   logic            valid_q;
   logic            regwrite_q;
   logic [4:0]      rd_q;
   logic [1:0]      src_q;
   logic [2:0]      f3_q;
   logic [XLEN-1:0] data_q;
   logic [XLEN-1:0] alu_q;
   logic [XLEN-1:0] pc4_q;
   logic [XLEN-1:0] csr_q;

   logic [OFF_W-1:0] off;
   logic [XLEN-1:0]  lane;
   logic [XLEN-1:0]  load_val;
   logic [XLEN-1:0]  result;

   // Pipeline register: stall holds everything, flush only kills valid/regwrite
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q    <= 1'b0;
         regwrite_q <= 1'b0;
         rd_q       <= '0;
         src_q      <= '0;
         f3_q       <= '0;
         data_q     <= '0;
         alu_q      <= '0;
         pc4_q      <= '0;
         csr_q      <= '0;
      end else if (!stall) begin
         if (flush) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
         end else begin
            valid_q    <= bus.valid_mem;
            regwrite_q <= bus.Reg_write_mem;
            rd_q       <= bus.rd_mem;
            src_q      <= bus.Result_src_mem;
            f3_q       <= bus.funct3_mem;
            data_q     <= bus.mem_read_data_mem;
            alu_q      <= bus.alu_result_mem;
            pc4_q      <= bus.pc_plus4_mem;
            csr_q      <= bus.csr_rdata_mem;
         end
      end
   end

   // Retire counter: an instruction retires when it leaves WB unstalled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instret <= '0;
      end else if (valid_q && !stall) begin
         instret <= instret + CNT_W'(1);
      end
   end

   // Load extraction: shift the addressed lane down, then size/sign-extend
   always_comb begin
      off  = alu_q[OFF_W-1:0];
      lane = data_q >> {off, 3'b000};
      load_val = data_q;
      case (f3_q)
         3'b000: load_val = XLEN'($signed(lane[7:0]));
         3'b100: load_val = XLEN'(lane[7:0]);
         3'b001: load_val = XLEN'($signed(lane[15:0]));
         3'b101: load_val = XLEN'(lane[15:0]);
         3'b010: load_val = XLEN'($signed(lane[31:0]));
         3'b110: if (XLEN == 64) load_val = XLEN'(lane[31:0]);
         3'b011: if (XLEN == 64) load_val = lane;
         default: load_val = data_q;
      endcase
   end

   // Result source selection
   always_comb begin
      result = alu_q;
      case (src_q)
         2'b00: result = alu_q;
         2'b01: result = load_val;
         2'b10: result = pc4_q;
         2'b11: result = csr_q;
         default: result = alu_q;
      endcase
   end

   assign bus.wb_data  = result;
   assign bus.wb_rd    = rd_q;
   assign bus.wb_valid = valid_q;
   assign bus.wb_we    = valid_q & regwrite_q & ~(ZERO_GUARD & (rd_q == 5'd0));

endmodule
